// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode encodings, latencies and state type for the multiply/divide unit.
package mdu_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;
    localparam logic [3:0] MD_MADD  = 4'd9;
    localparam logic [3:0] MD_MADDU = 4'd10;

    localparam logic [3:0] MD_MULT_CYC = 4'd5;
    localparam logic [3:0] MD_DIV_CYC  = 4'd10;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and quotient/remainder datapath for mdu_ctrl.
module mdu_arith (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_signed,
    input  logic        i_div,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_divZero
);

    logic [63:0] w_prod;
    logic        w_aNeg;
    logic        w_bNeg;
    logic [31:0] w_aMag;
    logic [31:0] w_bMag;
    logic [31:0] w_qMag;
    logic [31:0] w_rMag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign o_divZero = (i_b == 32'd0);

    // Signed division goes through magnitudes so INT_MIN / -1 wraps instead of trapping
    always_comb begin
        if (i_signed) begin
            w_prod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
        end else begin
            w_prod = {32'd0, i_a} * {32'd0, i_b};
        end
        w_aNeg = i_signed & i_a[31];
        w_bNeg = i_signed & i_b[31];
        w_aMag = w_aNeg ? (32'd0 - i_a) : i_a;
        w_bMag = w_bNeg ? (32'd0 - i_b) : i_b;
        if (o_divZero) begin
            w_bMag = 32'd1;
        end
        w_qMag = w_aMag / w_bMag;
        w_rMag = w_aMag % w_bMag;
        w_quot = (w_aNeg ^ w_bNeg) ? (32'd0 - w_qMag) : w_qMag;
        w_rem  = w_aNeg ? (32'd0 - w_rMag) : w_rMag;
    end

    assign o_hi = i_div ? w_rem  : w_prod[63:32];
    assign o_lo = i_div ? w_quot : w_prod[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO sequencer: latches the result at start and commits it when the count expires.
// Optional macro MDU_MADD_EN enables madd/maddu accumulation into {HI,LO}.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] r_hi, r_lo, r_pendHi, r_pendLo;
    logic [3:0]  r_cnt;
    logic        r_pendAcc, r_pendSkip;

    logic [31:0] w_hiNext, w_loNext, w_pendHiNext, w_pendLoNext;
    logic [3:0]  w_cntNext;
    logic        w_pendAccNext, w_pendSkipNext;

    logic        w_isMacc, w_isMul, w_isDiv, w_signed;
    logic [31:0] w_arithHi, w_arithLo;
    logic        w_divZero;
    mdu_state_e  w_state;

`ifdef MDU_MADD_EN
    assign w_isMacc = (mdop == MD_MADD) || (mdop == MD_MADDU);
`else
    assign w_isMacc = 1'b0;
`endif

    assign w_isMul  = (mdop == MD_MULT) || (mdop == MD_MULTU) || w_isMacc;
    assign w_isDiv  = (mdop == MD_DIV) || (mdop == MD_DIVU);
    assign w_signed = (mdop == MD_MULT) || (mdop == MD_DIV) || (mdop == MD_MADD);
    assign w_state  = (r_cnt != 4'd0) ? ST_BUSY : ST_IDLE;

    mdu_arith u_arith (
        .i_a       (A),
        .i_b       (B),
        .i_signed  (w_signed),
        .i_div     (w_isDiv),
        .o_hi      (w_arithHi),
        .o_lo      (w_arithLo),
        .o_divZero (w_divZero)
    );

    always_comb begin
        w_hiNext       = r_hi;
        w_loNext       = r_lo;
        w_pendHiNext   = r_pendHi;
        w_pendLoNext   = r_pendLo;
        w_cntNext      = r_cnt;
        w_pendAccNext  = r_pendAcc;
        w_pendSkipNext = r_pendSkip;
        case (w_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_isMul || w_isDiv) begin
                        w_pendHiNext   = w_arithHi;
                        w_pendLoNext   = w_arithLo;
                        w_cntNext      = w_isMul ? MD_MULT_CYC : MD_DIV_CYC;
                        w_pendAccNext  = w_isMacc;
                        w_pendSkipNext = w_isDiv && w_divZero;
                    end else if (mdop == MD_MTHI) begin
                        w_hiNext = A;
                    end else if (mdop == MD_MTLO) begin
                        w_loNext = A;
                    end
                end
            end
            ST_BUSY: begin
                w_cntNext = r_cnt - 4'd1;
                // Commit on the final busy edge; a divide by zero only burns the latency
                if ((r_cnt == 4'd1) && !r_pendSkip) begin
                    if (r_pendAcc) begin
                        {w_hiNext, w_loNext} = {r_hi, r_lo} + {r_pendHi, r_pendLo};
                    end else begin
                        w_hiNext = r_pendHi;
                        w_loNext = r_pendLo;
                    end
                end
            end
            default: begin
                w_cntNext = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_pendHi   <= 32'd0;
            r_pendLo   <= 32'd0;
            r_cnt      <= 4'd0;
            r_pendAcc  <= 1'b0;
            r_pendSkip <= 1'b0;
        end else begin
            r_hi       <= w_hiNext;
            r_lo       <= w_loNext;
            r_pendHi   <= w_pendHiNext;
            r_pendLo   <= w_pendLoNext;
            r_cnt      <= w_cntNext;
            r_pendAcc  <= w_pendAccNext;
            r_pendSkip <= w_pendSkipNext;
        end
    end

    assign busy = (r_cnt != 4'd0);
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign out  = (mdop == MD_MFHI) ? r_hi :
                  (mdop == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl; expected {HI,LO} are queued at issue and popped at completion.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdop = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] out, hi, lo;

    int nChecks = 0;
    int nErrors = 0;
    logic [63:0] expQ[$];

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .out   (out),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle; returns at the negedge after the start edge
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        mdop  = MD_NONE;
        A     = 32'd0;
        B     = 32'd0;
    endtask

    task automatic waitIdle(input string tag, input int expCyc);
        int n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
        end
        check32({tag, ".busyCycles"}, n, expCyc);
    endtask

    task automatic checkOutput(input string tag);
        logic [63:0] e;
        if (expQ.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL %s scoreboard empty observed=%h_%h expected=none", tag, hi, lo);
        end else begin
            e = expQ.pop_front();
            check32({tag, ".hi"}, hi, e[63:32]);
            check32({tag, ".lo"}, lo, e[31:0]);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mdop  = MD_MFHI;
        #1;
        check32("reset.busy", {31'd0, busy}, 32'd0);
        check32("reset.hi", hi, 32'd0);
        check32("reset.lo", lo, 32'd0);
        check32("reset.out", out, 32'd0);
        mdop = MD_NONE;

        expQ.push_back(64'hFFFFFFFF_FFFFFFFE);
        applyStimulus(MD_MULT, 32'hFFFFFFFF, 32'd2);
        waitIdle("mult", 5);
        checkOutput("mult");

        expQ.push_back(64'h00000001_FFFFFFFE);
        applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        waitIdle("multu", 5);
        checkOutput("multu");

        expQ.push_back(64'hFFFFFFFF_FFFFFFFD);
        applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2);
        waitIdle("div", 10);
        checkOutput("div");

        expQ.push_back(64'hFFFFFFFF_FFFFFFFD);
        applyStimulus(MD_DIVU, 32'd7, 32'd0);
        waitIdle("divu0", 10);
        checkOutput("divu0");

        expQ.push_back(64'h00000055_FFFFFFFD);
        applyStimulus(MD_MTHI, 32'h55, 32'd0);
        waitIdle("mthi", 0);
        checkOutput("mthi");

        // mthi mid-mult is ignored; out shows pre-operation HI/LO while busy
        expQ.push_back(64'h00000000_0000000F);
        applyStimulus(MD_MULT, 32'd3, 32'd5);
        @(negedge clk);
        mdop = MD_MFHI;
        #1;
        check32("busy.outHi", out, 32'h55);
        @(negedge clk);
        start = 1'b1;
        mdop  = MD_MTHI;
        A     = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        mdop  = MD_MFLO;
        A     = 32'd0;
        #1;
        check32("busy.outLo", out, 32'hFFFFFFFD);
        waitIdle("multIgnore", 2);
        #1;
        check32("mfloFall.out", out, 32'h0000000F);
        checkOutput("multIgnore");
        mdop = MD_NONE;

        // Start on the same cycle busy falls is accepted
        expQ.push_back(64'h00000000_00000006);
        applyStimulus(MD_MULT, 32'd2, 32'd3);
        waitIdle("multB2B", 5);
        checkOutput("multB2B");
        start = 1'b1;
        mdop  = MD_MTLO;
        A     = 32'h0000ABCD;
        expQ.push_back(64'h00000000_0000ABCD);
        @(negedge clk);
        start = 1'b0;
        mdop  = MD_NONE;
        A     = 32'd0;
        check32("b2b.busy", {31'd0, busy}, 32'd0);
        checkOutput("b2b");

        expQ.push_back(64'h00000000_0000ABCD);
        applyStimulus(4'd11, 32'd5, 32'd5);
        waitIdle("badOp", 0);
        checkOutput("badOp");

        // Reset during the fourth busy cycle of a divide
        applyStimulus(MD_MTHI, 32'h77, 32'd0);
        applyStimulus(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("rstDiv.busy", {31'd0, busy}, 32'd0);
        check32("rstDiv.hi", hi, 32'd0);
        check32("rstDiv.lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        check32("rstDiv.hiLater", hi, 32'd0);
        check32("rstDiv.loLater", lo, 32'd0);

        applyStimulus(MD_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
        expQ.push_back(64'h00000001_00000000);
        applyStimulus(MD_MADDU, 32'd1, 32'd1);
        waitIdle("maddu", 5);
        checkOutput("maddu");
        expQ.push_back(64'h00000000_FFFFFFFF);
        applyStimulus(MD_MADD, 32'hFFFFFFFF, 32'd1);
        waitIdle("madd", 5);
        checkOutput("madd");
`else
        expQ.push_back(64'h00000000_FFFFFFFF);
        applyStimulus(MD_MADDU, 32'd1, 32'd1);
        waitIdle("maddu", 0);
        checkOutput("maddu");
        expQ.push_back(64'h00000000_FFFFFFFF);
        applyStimulus(MD_MADD, 32'hFFFFFFFF, 32'd1);
        waitIdle("madd", 0);
        checkOutput("madd");
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updated on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-003 SHALL have ports: start  in  1  E-stage qualifier; mdop is acted on only when start=1.
REQ-004 SHALL have ports: mdop  in  4  operation code (0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu; others = none).
REQ-005 SHALL have ports: A, B  in  32 each  forwarded rs/rt operands.
REQ-006 SHALL have ports: busy  out  1  high while a mult/div is in progress.
REQ-007 SHALL have ports: out  out  32  HI when mdop=mfhi, LO when mdop=mflo, else 0; combinational read of current HI/LO.
REQ-008 SHALL have ports: hi, lo  out  32 each  current HI/LO register values (debug/trace).

Function
REQ-009 SHALL hold state: HI[31:0], LO[31:0], cnt[3:0], pend_hi/pend_lo[31:0] (latched result), pend_acc (accumulate flag).
REQ-010 SHALL be in IDLE when cnt==0 and in BUSY when cnt!=0; busy = (cnt!=0), registered.
REQ-011 SHALL, in IDLE with start=1 and mdop in {mult,multu,madd,maddu}, latch the 64-bit product (signed for mult/madd, unsigned otherwise) into pend_hi:pend_lo and load cnt=5.
REQ-012 SHALL, in IDLE with start=1 and mdop in {div,divu}, latch LO=quotient, HI=remainder (signed: truncate toward zero, remainder sign = dividend sign) into pend and load cnt=10.
REQ-013 SHALL, for div/divu with B==0, load cnt=10 and leave HI/LO unchanged at completion.
REQ-014 SHALL decrement cnt by 1 each cycle in BUSY; on the edge where cnt goes 1->0, write pend into HI/LO (or add pend to {HI,LO} mod 2^64 for madd/maddu) and deassert busy on that same edge.
REQ-015 SHALL therefore keep busy high for exactly 5 cycles (mult class) or 10 cycles (div class) following the start edge.
REQ-016 SHALL, in IDLE with start=1, write A into HI (mthi) or LO (mtlo) on the next edge, with busy remaining low.
REQ-017 SHALL ignore start completely (no latch, no HI/LO write, no cnt change) while in BUSY.
REQ-018 SHALL return pre-operation HI/LO on out during BUSY.
REQ-019 SHALL accept a new start on the first cycle with busy=0 after completion, with that operation observing the just-written HI/LO.
REQ-020 SHALL treat mfhi/mflo/none as no state change.

Reset
REQ-021 SHALL, when reset=0 at a rising edge, set HI=0, LO=0, cnt=0, pend=0, pend_acc=0, so that busy=0 and out=0 on the following cycle.
REQ-022 SHALL give reset priority over start, and SHALL discard any in-flight operation without writing HI/LO.

Configuration
REQ-023 SHALL use macro MDU_MADD_EN: when defined, madd/maddu (codes 9/10) accumulate per REQ-011/REQ-014.
REQ-024 SHALL, when MDU_MADD_EN is undefined, decode codes 9/10 as none, with no busy assertion and no state change.

Structure
REQ-025 SHALL take mdop codes and latencies (MD_MULT_CYC=5, MD_DIV_CYC=10) from the shared const.v as `MD_* macros, also used by CU and the hazard unit.
REQ-026 SHALL place the 64-bit product/quotient/remainder logic in one combinational sub-module mdu_arith; all sequencing SHALL remain in mdu_ctrl.

Verification
REQ-027 SHALL be covered by test: mult A=0xFFFFFFFF B=2, start 1 cycle -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 SHALL be covered by test: div A=-7 (0xFFFFFFF9) B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7 B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-029 SHALL be covered by test: start mthi A=0x1234 during cycle 3 of a mult -> ignored, HI equals the mult result afterwards, not 0x1234.
REQ-030 SHALL be covered by test: reset=0 in cycle 4 of a div -> next cycle busy=0, HI=LO=0, no later write.
REQ-031 SHALL be covered by test: with MDU_MADD_EN, HI:LO=0:0xFFFFFFFF, then maddu A=1 B=1 -> HI=1, LO=0 after 5 cycles; without the macro, the same stimulus gives busy=0 and no change.
REQ-032 SHALL be covered by test: mflo issued the cycle busy falls -> out = new LO; a start in that same cycle is accepted.
